// File: rtl/ser_pkg.sv
// Shared types for the serializer pipeline: table entry layout, entry
// classification and walker error codes.
package ser_pkg;

  typedef struct packed {
    logic [31:0] offset;
    logic [31:0] size;
    logic [31:0] field_id;
    logic [4:0]  field_type;
    logic        nested;
    logic [25:0] rsvd;
  } table_entry_t;

  typedef enum logic [1:0] {
    ENT_LEAF,
    ENT_FOOTER,
    ENT_HEADER
  } entry_class_t;

  localparam logic [1:0] ERR_NONE       = 2'b00;
  localparam logic [1:0] ERR_OVERFLOW   = 2'b01;
  localparam logic [1:0] ERR_UNDERFLOW  = 2'b10;
  localparam logic [1:0] ERR_UNBALANCED = 2'b11;

  // A zero field_id marks a footer regardless of the nested bit.
  function automatic entry_class_t classify(input table_entry_t e);
    if (e.field_id == '0) return ENT_FOOTER;
    if (e.nested)         return ENT_HEADER;
    return ENT_LEAF;
  endfunction

endpackage

// File: rtl/base_stack.sv
// LIFO of 64-bit object base addresses used to save/restore the walker's
// current base across nested objects.
module base_stack #(
  parameter int unsigned STACK_DEPTH = 16
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic [63:0] i_din,
  output logic [63:0] o_top,
  output logic        o_full,
  output logic        o_empty
);

  localparam int unsigned PW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PW-1:0] r_sp;
  logic [63:0]   r_mem [STACK_DEPTH];
  logic [PW-1:0] w_sp_m1;

  assign w_sp_m1 = r_sp - PW'(1);
  assign o_full  = (r_sp == PW'(STACK_DEPTH));
  assign o_empty = (r_sp == '0);
  assign o_top   = o_empty ? '0 : r_mem[w_sp_m1[AW-1:0]];

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_sp <= '0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clear) begin
      r_sp <= '0;
    end else if (i_push && !o_full) begin
      r_mem[r_sp[AW-1:0]] <= i_din;
      r_sp                <= r_sp + PW'(1);
    end else if (i_pop && !o_empty) begin
      r_sp <= w_sp_m1;
    end
  end

endmodule

// File: rtl/ser_table_walker.sv
// Walks a field-descriptor table back to front, tracking nested object bases,
// and hands leaf fields one at a time to ser_aggregate.
module ser_table_walker
  import ser_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 16,
  parameter int unsigned ENTRY_BYTES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [63:0]  obj_base,
  input  logic [63:0]  tbl_base,
  input  logic [15:0]  tbl_count,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [1:0]   err_code,
  output logic         tbl_rd_en,
  output logic [63:0]  tbl_rd_addr,
  input  table_entry_t tbl_rd_data,
  input  logic         tbl_rd_valid,
  output logic         agg_en,
  output logic         agg_entry_valid,
  output table_entry_t agg_entry,
  output logic [63:0]  agg_addr,
  input  logic         agg_ready,
  input  logic         agg_done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_FETCH_WAIT,
    S_DECODE,
    S_ISSUE,
    S_WAIT_DONE,
    S_NEXT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t       r_state, w_next;
  logic [63:0]  r_base;
  logic [15:0]  r_idx;
  table_entry_t r_entry;
  logic [1:0]   r_err_code;
  logic         r_error, r_done, r_busy, r_rd_en, r_agg_valid;
  logic [63:0]  r_rd_addr, r_agg_addr;
  table_entry_t r_agg_entry;

  logic         w_accept, w_push, w_pop, w_full, w_empty, w_err_set;
  logic [1:0]   w_err_val;
  logic [63:0]  w_top, w_first_addr, w_field_addr;
  entry_class_t w_class;

  assign w_accept     = (r_state == S_IDLE) && start;
  assign w_class      = classify(r_entry);
  assign w_first_addr = tbl_base + 64'(tbl_count - 16'd1) * 64'(ENTRY_BYTES);
  assign w_field_addr = r_base + 64'(r_entry.offset);

  base_stack #(.STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk     (clk),
    .i_rst   (reset),
    .i_clear (w_accept),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (r_base),
    .o_top   (w_top),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_next    = r_state;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_err_set = 1'b0;
    w_err_val = ERR_NONE;
    case (r_state)
      S_IDLE:       if (start) w_next = (tbl_count == '0) ? S_DONE : S_FETCH;
      S_FETCH:      w_next = S_FETCH_WAIT;
      S_FETCH_WAIT: if (tbl_rd_valid) w_next = S_DECODE;
      S_DECODE: begin
        case (w_class)
          ENT_FOOTER: begin
            if (w_full) begin
              w_err_set = 1'b1;
              w_err_val = ERR_OVERFLOW;
              w_next    = S_ERROR;
            end else begin
              w_push = 1'b1;
              w_next = S_NEXT;
            end
          end
          ENT_HEADER: begin
            if (w_empty) begin
              w_err_set = 1'b1;
              w_err_val = ERR_UNDERFLOW;
              w_next    = S_ERROR;
            end else begin
              w_pop  = 1'b1;
              w_next = S_NEXT;
            end
          end
          default:    w_next = S_ISSUE;
        endcase
      end
      S_ISSUE:      if (agg_ready) w_next = S_WAIT_DONE;
      S_WAIT_DONE:  if (agg_done) w_next = S_NEXT;
      S_NEXT: begin
        if (r_idx == '0) begin
          w_next = S_DONE;
          if (!w_empty) begin
            w_err_set = 1'b1;
            w_err_val = ERR_UNBALANCED;
          end
        end else begin
          w_next = S_FETCH;
        end
      end
      default:      w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they belong to rather than lagging it by a cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_idx       <= '0;
      r_entry     <= '0;
      r_err_code  <= '0;
      r_error     <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_agg_valid <= 1'b0;
      r_agg_entry <= '0;
      r_agg_addr  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_base     <= obj_base;
        r_idx      <= tbl_count - 16'd1;
        r_rd_addr  <= w_first_addr;
        r_err_code <= ERR_NONE;
        r_error    <= 1'b0;
      end
      if ((r_state == S_FETCH_WAIT) && tbl_rd_valid) r_entry <= tbl_rd_data;
      if (w_push) r_base <= w_field_addr;
      if (w_pop)  r_base <= w_top;
      if (w_err_set) r_err_code <= w_err_val;
      if ((r_state == S_NEXT) && (r_idx != '0)) begin
        r_idx     <= r_idx - 16'd1;
        r_rd_addr <= r_rd_addr - 64'(ENTRY_BYTES);
      end
      if (r_state == S_DONE)  r_error <= (r_err_code != ERR_NONE);
      if (r_state == S_ERROR) r_error <= 1'b1;
      r_done      <= (r_state == S_DONE) || (r_state == S_ERROR);
      r_busy      <= (w_next != S_IDLE);
      r_rd_en     <= (w_next == S_FETCH);
      r_agg_valid <= (w_next == S_ISSUE);
      r_agg_entry <= (w_next == S_ISSUE) ? r_entry : '0;
      r_agg_addr  <= (w_next == S_ISSUE) ? w_field_addr : '0;
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign error           = r_error;
  assign err_code        = r_err_code;
  assign tbl_rd_en       = r_rd_en;
  assign tbl_rd_addr     = r_rd_addr;
  assign agg_en          = r_agg_valid;
  assign agg_entry_valid = r_agg_valid;
  assign agg_entry       = r_agg_entry;
  assign agg_addr        = r_agg_addr;

endmodule

// File: tb/tb_ser_table_walker.sv
// Bench for ser_table_walker: table memory and aggregate-stage responders
// plus a queue-based reference walk of the descriptor table.
module tb_ser_table_walker;
  import ser_pkg::*;

  logic         clk, reset, start;
  logic [63:0]  obj_base, tbl_base;
  logic [15:0]  tbl_count;
  logic         busy, done, error, tbl_rd_en, tbl_rd_valid;
  logic [1:0]   err_code;
  logic [63:0]  tbl_rd_addr, agg_addr;
  table_entry_t tbl_rd_data, agg_entry;
  logic         agg_en, agg_entry_valid, agg_ready, agg_done;

  ser_table_walker #(.STACK_DEPTH(16), .ENTRY_BYTES(16)) dut (
    .clk(clk), .reset(reset), .start(start), .obj_base(obj_base),
    .tbl_base(tbl_base), .tbl_count(tbl_count), .busy(busy), .done(done),
    .error(error), .err_code(err_code), .tbl_rd_en(tbl_rd_en),
    .tbl_rd_addr(tbl_rd_addr), .tbl_rd_data(tbl_rd_data),
    .tbl_rd_valid(tbl_rd_valid), .agg_en(agg_en),
    .agg_entry_valid(agg_entry_valid), .agg_entry(agg_entry),
    .agg_addr(agg_addr), .agg_ready(agg_ready), .agg_done(agg_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  table_entry_t tbl [64];
  int           tbl_n;
  logic [63:0]  cur_tb;

  logic [63:0]  obs_rd[$], obs_iss[$], vld_addr[$];
  table_entry_t obs_ent[$];
  int           mon_done_cnt, mon_en_cnt, mon_en_bad, mon_busy_bad;
  logic         mon_err;
  logic [1:0]   mon_code;
  int           rdy_mode, stall_left, done_delay;

  logic [63:0]  exp_rd[$], exp_iss[$];
  table_entry_t exp_ent[$];
  logic [1:0]   exp_err;

  function automatic table_entry_t mk(input logic [31:0] off, input int kind);
    table_entry_t e;
    e.offset     = off;
    e.size       = $urandom;
    e.field_type = 5'($urandom);
    e.rsvd       = 26'($urandom);
    e.field_id   = (kind == 1) ? 32'h0 : ($urandom | 32'h1);
    e.nested     = (kind == 2) ? 1'b1 : ((kind == 1) ? 1'($urandom) : 1'b0);
    return e;
  endfunction

  function automatic table_entry_t lookup(input logic [63:0] a);
    logic [63:0] k;
    k = (a - cur_tb) >> 4;
    if (k < 64'(tbl_n) && (a[3:0] == (cur_tb[3:0]))) return tbl[k[5:0]];
    return '0;
  endfunction

  // Reference: walk indices high to low, keep the base stack in a queue.
  task automatic model(input logic [63:0] ob);
    logic [63:0] stk[$];
    logic [63:0] base;
    exp_rd.delete(); exp_iss.delete(); exp_ent.delete();
    exp_err = 2'd0;
    base = ob;
    for (int i = tbl_n - 1; i >= 0; i--) begin
      exp_rd.push_back(cur_tb + 64'(i) * 64'd16);
      if (tbl[i].field_id == 0) begin
        if (stk.size() == 16) begin exp_err = 2'd1; return; end
        stk.push_back(base);
        base = base + {32'h0, tbl[i].offset};
      end else if (tbl[i].nested) begin
        if (stk.size() == 0) begin exp_err = 2'd2; return; end
        base = stk.pop_back();
      end else begin
        exp_iss.push_back(base + {32'h0, tbl[i].offset});
        exp_ent.push_back(tbl[i]);
      end
    end
    if (stk.size() != 0) exp_err = 2'd3;
  endtask

  // Table memory and aggregate-stage responders, acting on the falling edge.
  initial begin
    logic        rd_pend, dn_armed;
    int          rd_cnt, dn_cnt;
    logic [63:0] rd_a;
    rd_pend = 0; dn_armed = 0; rd_cnt = 0; dn_cnt = 0; rd_a = '0;
    tbl_rd_valid = 0; tbl_rd_data = '0; agg_ready = 0; agg_done = 0;
    forever begin
      @(negedge clk);
      tbl_rd_valid = 1'b0;
      if (rd_pend) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          rd_pend = 0; tbl_rd_valid = 1'b1; tbl_rd_data = lookup(rd_a);
        end
      end
      if (tbl_rd_en === 1'b1) begin
        obs_rd.push_back(tbl_rd_addr);
        rd_pend = 1; rd_cnt = $urandom_range(1, 4); rd_a = tbl_rd_addr;
      end
      agg_done = 1'b0;
      if (dn_armed) begin
        dn_cnt--;
        if (dn_cnt == 0) begin dn_armed = 0; agg_done = 1'b1; end
      end
      if (agg_en !== agg_entry_valid) mon_en_bad++;
      if (agg_en === 1'b1) mon_en_cnt++;
      if (agg_entry_valid === 1'b1) begin
        vld_addr.push_back(agg_addr);
        if (rdy_mode == 2 && stall_left > 0) begin
          stall_left--; agg_ready = 1'b0;
        end else if (rdy_mode == 1 && $urandom_range(0, 1) == 0) begin
          agg_ready = 1'b0;
          if ($urandom_range(0, 3) == 0) agg_done = 1'b1;
        end else begin
          agg_ready = 1'b1;
          obs_iss.push_back(agg_addr); obs_ent.push_back(agg_entry);
          dn_armed = 1; dn_cnt = done_delay;
        end
      end else begin
        agg_ready = 1'($urandom_range(0, 1));
      end
      if (done === 1'b1) begin
        mon_done_cnt++; mon_err = error; mon_code = err_code;
        if (busy !== 1'b0) mon_busy_bad++;
      end
    end
  end

  task automatic clear_obs();
    @(posedge clk); #1;
    obs_rd.delete(); obs_iss.delete(); obs_ent.delete(); vld_addr.delete();
    mon_done_cnt = 0; mon_en_cnt = 0; mon_en_bad = 0; mon_busy_bad = 0;
    mon_err = 1'b0; mon_code = 2'd0;
  endtask

  task automatic do_walk(input logic [63:0] ob, input logic [63:0] tb,
                         output logic rden_c1, output logic timed_out);
    clear_obs();
    cur_tb = tb;
    @(negedge clk);
    obj_base = ob; tbl_base = tb; tbl_count = 16'(tbl_n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rden_c1 = tbl_rd_en;
    timed_out = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      if (mon_done_cnt > 0) begin timed_out = 1'b0; break; end
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({busy, done, error, err_code, tbl_rd_en, agg_en, agg_entry_valid} !== '0 ||
        tbl_rd_addr !== '0 || agg_addr !== '0 || agg_entry !== '0) begin
      bad++; $display("FAIL reset_outputs: got ctl=%b rd_addr=%h agg_addr=%h, want all 0",
        {busy, done, error, err_code, tbl_rd_en, agg_en, agg_entry_valid}, tbl_rd_addr, agg_addr);
    end
  endtask

  task automatic test_empty();
    clear_obs();
    @(negedge clk);
    tbl_count = 16'd0; obj_base = 64'h1000; tbl_base = 64'h2000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL empty_cycle1: busy=%b done=%b, want busy=1 done=0", busy, done);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
      bad++; $display("FAIL empty_cycle2: done=%b busy=%b error=%b, want 1 0 0", done, busy, error);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || obs_rd.size() != 0) begin
      bad++; $display("FAIL empty_after: done=%b reads=%0d, want 0 0", done, obs_rd.size());
    end
  endtask

  task automatic test_three_leaves();
    logic r1, to;
    logic [63:0] tb;
    tb = {$urandom, $urandom} & ~64'hF;
    tbl_n = 3; tbl[0] = mk(0, 0); tbl[1] = mk(8, 0); tbl[2] = mk(16, 0);
    rdy_mode = 0; done_delay = 5;
    do_walk(64'h1000, tb, r1, to);
    total++;
    if (to || r1 !== 1'b1) begin
      bad++; $display("FAIL three_start: timeout=%b rd_en_cycle1=%b, want 0 1", to, r1);
    end
    total++;
    if (obs_rd.size() != 3 || obs_rd[0] !== tb + 64'h20 || obs_rd[1] !== tb + 64'h10 || obs_rd[2] !== tb) begin
      bad++; $display("FAIL three_reads: got %0d reads first=%h, want 3 reads from %h", obs_rd.size(),
        (obs_rd.size() > 0) ? obs_rd[0] : 64'h0, tb + 64'h20);
    end
    total++;
    if (obs_iss.size() != 3 || obs_iss[0] !== 64'h1010 || obs_iss[1] !== 64'h1008 || obs_iss[2] !== 64'h1000 ||
        obs_ent[0] !== tbl[2] || obs_ent[2] !== tbl[0]) begin
      bad++; $display("FAIL three_issues: got %0d issues first=%h, want 3 issues 1010/1008/1000",
        obs_iss.size(), (obs_iss.size() > 0) ? obs_iss[0] : 64'h0);
    end
    total++;
    if (mon_done_cnt != 1 || mon_err !== 1'b0 || mon_code !== 2'd0 || mon_busy_bad != 0) begin
      bad++; $display("FAIL three_done: pulses=%0d error=%b code=%0d busy_bad=%0d, want 1 0 0 0",
        mon_done_cnt, mon_err, mon_code, mon_busy_bad);
    end
  endtask

  task automatic test_nested();
    logic r1, to;
    tbl_n = 4; tbl[0] = mk(4, 0); tbl[1] = mk(0, 2); tbl[2] = mk(8, 0); tbl[3] = mk(32'h40, 1);
    rdy_mode = 0; done_delay = 3;
    do_walk(64'h1000, 64'h4000, r1, to);
    total++;
    if (to || obs_iss.size() != 2 || obs_iss[0] !== 64'h1048 || obs_iss[1] !== 64'h1004) begin
      bad++; $display("FAIL nested_issues: timeout=%b count=%0d first=%h, want 2 issues 1048/1004",
        to, obs_iss.size(), (obs_iss.size() > 0) ? obs_iss[0] : 64'h0);
    end
    total++;
    if (mon_done_cnt != 1 || mon_err !== 1'b0 || mon_code !== 2'd0 || obs_rd.size() != 4) begin
      bad++; $display("FAIL nested_done: pulses=%0d error=%b code=%0d reads=%0d, want 1 0 0 4",
        mon_done_cnt, mon_err, mon_code, obs_rd.size());
    end
  endtask

  task automatic test_overflow();
    logic r1, to;
    tbl_n = 17;
    for (int i = 0; i < 17; i++) tbl[i] = mk($urandom_range(0, 255), 1);
    do_walk(64'h8000, 64'h0, r1, to);
    total++;
    if (to || mon_done_cnt != 1 || mon_err !== 1'b1 || mon_code !== 2'd1) begin
      bad++; $display("FAIL overflow: timeout=%b pulses=%0d error=%b code=%0d, want 0 1 1 1",
        to, mon_done_cnt, mon_err, mon_code);
    end
    total++;
    if (mon_en_cnt != 0 || obs_rd.size() != 17) begin
      bad++; $display("FAIL overflow_traffic: agg_en cycles=%0d reads=%0d, want 0 17", mon_en_cnt, obs_rd.size());
    end
  endtask

  task automatic test_underflow_unbalanced();
    logic r1, to;
    tbl_n = 1; tbl[0] = mk(0, 2);
    do_walk(64'h100, 64'h300, r1, to);
    total++;
    if (to || mon_done_cnt != 1 || mon_err !== 1'b1 || mon_code !== 2'd2) begin
      bad++; $display("FAIL underflow: timeout=%b pulses=%0d error=%b code=%0d, want 0 1 1 2",
        to, mon_done_cnt, mon_err, mon_code);
    end
    @(negedge clk);
    total++;
    if (error !== 1'b1) begin
      bad++; $display("FAIL error_sticky: error=%b, want 1", error);
    end
    tbl[0] = mk(16, 1);
    do_walk(64'h100, 64'h300, r1, to);
    total++;
    if (to || mon_done_cnt != 1 || mon_err !== 1'b1 || mon_code !== 2'd3 || mon_en_cnt != 0) begin
      bad++; $display("FAIL unbalanced: timeout=%b pulses=%0d error=%b code=%0d agg_en=%0d, want 0 1 1 3 0",
        to, mon_done_cnt, mon_err, mon_code, mon_en_cnt);
    end
  endtask

  task automatic test_back_pressure();
    logic r1, to;
    logic [63:0] ob;
    int held_bad;
    ob = {$urandom, $urandom};
    tbl_n = 1; tbl[0] = mk(32'h24, 0);
    rdy_mode = 2; stall_left = 4; done_delay = 2;
    do_walk(ob, 64'h9000, r1, to);
    held_bad = 0;
    foreach (vld_addr[i]) if (vld_addr[i] !== ob + 64'h24) held_bad++;
    total++;
    if (to || vld_addr.size() != 5 || held_bad != 0) begin
      bad++; $display("FAIL bp_hold: timeout=%b valid_cycles=%0d wrong_addr=%0d, want 0 5 0",
        to, vld_addr.size(), held_bad);
    end
    total++;
    if (obs_iss.size() != 1 || obs_ent[0] !== tbl[0] || mon_en_bad != 0 || mon_err !== 1'b0) begin
      bad++; $display("FAIL bp_accept: issues=%0d en_bad=%0d error=%b, want 1 0 0",
        obs_iss.size(), mon_en_bad, mon_err);
    end
    rdy_mode = 0;
  endtask

  task automatic test_reset_mid();
    logic seen;
    tbl_n = 2; tbl[0] = mk(0, 0); tbl[1] = mk(4, 0);
    rdy_mode = 0; done_delay = 20;
    clear_obs();
    cur_tb = 64'h500;
    @(negedge clk);
    obj_base = 64'h700; tbl_base = 64'h500; tbl_count = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      if (obs_iss.size() > 0) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL rst_mid_issue: no issue seen, want 1 issue"); end
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({busy, done, error, err_code, tbl_rd_en, agg_en, agg_entry_valid} !== '0 ||
        tbl_rd_addr !== '0 || agg_addr !== '0 || agg_entry !== '0) begin
      bad++; $display("FAIL rst_mid_outputs: ctl=%b rd_addr=%h agg_addr=%h, want all 0",
        {busy, done, error, err_code, tbl_rd_en, agg_en, agg_entry_valid}, tbl_rd_addr, agg_addr);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || mon_done_cnt != 0 || obs_rd.size() != 1 || obs_iss.size() != 1) begin
      bad++; $display("FAIL rst_mid_late_done: busy=%b pulses=%0d reads=%0d issues=%0d, want 0 0 1 1",
        busy, mon_done_cnt, obs_rd.size(), obs_iss.size());
    end
  endtask

  task automatic test_random();
    logic r1, to;
    logic [63:0] ob, tb;
    int open, r, wrong;
    rdy_mode = 1;
    for (int w = 0; w < 24; w++) begin
      tbl_n = $urandom_range(0, 12);
      open = 0;
      for (int i = 0; i < tbl_n; i++) begin
        r = $urandom_range(0, 9);
        if (w % 2 == 0) begin
          if (open > 0 && (r < 3 || tbl_n - i <= open)) begin tbl[i] = mk($urandom, 1); open--; end
          else if (r < 5 && open < 4 && tbl_n - i - 1 > open) begin tbl[i] = mk($urandom, 2); open++; end
          else tbl[i] = mk($urandom, 0);
        end else begin
          tbl[i] = mk($urandom, (r < 6) ? 0 : ((r < 8) ? 1 : 2));
        end
      end
      ob = {$urandom, $urandom};
      tb = {$urandom, $urandom} & ~64'hF;
      done_delay = $urandom_range(1, 6);
      cur_tb = tb;
      model(ob);
      do_walk(ob, tb, r1, to);
      wrong = 0;
      if (obs_rd.size() != exp_rd.size()) wrong++;
      else foreach (exp_rd[i]) if (obs_rd[i] !== exp_rd[i]) wrong++;
      total++;
      if (to || wrong != 0) begin
        bad++; $display("FAIL rand_reads[%0d]: timeout=%b got %0d reads (%0d wrong), want %0d",
          w, to, obs_rd.size(), wrong, exp_rd.size());
      end
      wrong = 0;
      if (obs_iss.size() != exp_iss.size()) wrong++;
      else foreach (exp_iss[i]) if (obs_iss[i] !== exp_iss[i] || obs_ent[i] !== exp_ent[i]) wrong++;
      total++;
      if (wrong != 0) begin
        bad++; $display("FAIL rand_issues[%0d]: got %0d issues (%0d wrong), want %0d",
          w, obs_iss.size(), wrong, exp_iss.size());
      end
      total++;
      if (mon_done_cnt != 1 || mon_code !== exp_err || mon_err !== (exp_err != 2'd0) ||
          mon_busy_bad != 0 || mon_en_bad != 0) begin
        bad++; $display("FAIL rand_status[%0d]: pulses=%0d code=%0d error=%b busy_bad=%0d en_bad=%0d, want 1 %0d %b 0 0",
          w, mon_done_cnt, mon_code, mon_err, mon_busy_bad, mon_en_bad, exp_err, exp_err != 2'd0);
      end
    end
    rdy_mode = 0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; obj_base = '0; tbl_base = '0; tbl_count = '0;
    tbl_n = 0; cur_tb = '0; rdy_mode = 0; stall_left = 0; done_delay = 5;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_reset();
    test_empty();
    test_three_leaves();
    test_nested();
    test_overflow();
    test_underflow_unbalanced();
    test_back_pressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
